// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file.
// master: ID-stage requester (read addresses, writes, clear request).
// slave: the register file (read data, init_busy).
//
// Signals:
//   clear_req  master->slave  one-cycle pulse starting a clear sequence
//   rd_addr    master->slave  NRD packed read addresses, port i at [i*AW +: AW]
//   rd_data    slave->master  NRD packed read data, port i at [i*XLEN +: XLEN]
//   we0/waddr0/wdata0  master->slave  write port 0
//   we1/waddr1/wdata1  master->slave  write port 1 (wins over port 0)
//   init_busy  slave->master  high while the array is being cleared
interface regfile_mp_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
);
    logic                 clear_req;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic                 we0;
    logic [AW-1:0]        waddr0;
    logic [XLEN-1:0]      wdata0;
    logic                 we1;
    logic [AW-1:0]        waddr1;
    logic [XLEN-1:0]      wdata1;
    logic                 init_busy;

    modport master (
        output clear_req,
        output rd_addr,
        input  rd_data,
        output we0,
        output waddr0,
        output wdata0,
        output we1,
        output waddr1,
        output wdata1,
        input  init_busy
    );

    modport slave (
        input  clear_req,
        input  rd_addr,
        output rd_data,
        input  we0,
        input  waddr0,
        input  wdata0,
        input  we1,
        input  waddr1,
        input  wdata1,
        output init_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with two prioritised write ports,
// optional write-to-read bypass and a hardware clear sequencer.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; restarts the clear sequence
//   bus    regfile_mp_if.slave: NRD combinational reads, writes on
//          ports 0/1 (port 1 wins), clear_req, registered init_busy
module regfile_mp #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    regfile_mp_if.slave   bus
);

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    localparam logic [AW-1:0] FIRST = AW'(1);
    localparam logic [AW-1:0] LAST  = AW'(NREG - 1);

    state_t              r_state;
    logic [AW-1:0]       r_ptr;
    logic                r_busy;

    // Entry 0 reads as zero and is never stored.
    logic [XLEN-1:0]     r_mem [1:NREG-1];

    logic                w_idle_wr;
    logic                w_wr0;
    logic                w_wr1;
    logic [NRD*XLEN-1:0] w_rd_data;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREG);
    endfunction

    // Writes are taken only in IDLE and never on the clear_req cycle.
    assign w_idle_wr = (r_state == S_IDLE) && !reset && !bus.clear_req;
    assign w_wr0     = w_idle_wr && bus.we0 && in_range(bus.waddr0);
    assign w_wr1     = w_idle_wr && bus.we1 && in_range(bus.waddr1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
            r_ptr   <= FIRST;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_ptr == LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + FIRST;
                    end
                end
                S_IDLE: begin
                    if (bus.clear_req) begin
                        r_state <= S_INIT;
                        r_ptr   <= FIRST;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_ptr   <= FIRST;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset: contents survive reset until the clear
    // sequence that follows release overwrites them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_INIT) begin
                r_mem[r_ptr] <= '0;
            end else begin
                if (w_wr0) begin
                    r_mem[bus.waddr0] <= bus.wdata0;
                end
                // Later assignment wins on an address collision.
                if (w_wr1) begin
                    r_mem[bus.waddr1] <= bus.wdata1;
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0]   v_a;
        logic [XLEN-1:0] v_d;
        w_rd_data = '0;
        v_a       = '0;
        v_d       = '0;
        for (int p = 0; p < NRD; p++) begin
            v_a = bus.rd_addr[p*AW +: AW];
            v_d = '0;
            if (!reset && !r_busy && in_range(v_a)) begin
                if (BYPASS != 0 && w_wr1 && bus.waddr1 == v_a) begin
                    v_d = bus.wdata1;
                end else if (BYPASS != 0 && w_wr0 && bus.waddr0 == v_a) begin
                    v_d = bus.wdata0;
                end else begin
                    v_d = r_mem[v_a];
                end
            end
            w_rd_data[p*XLEN +: XLEN] = v_d;
        end
    end

    assign bus.rd_data   = w_rd_data;
    assign bus.init_busy = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypassing 32-entry instance and a
// non-bypassing 20-entry instance driven with identical stimulus.
module tb_regfile_mp;

    localparam int XLEN = 64;
    localparam int NRD  = 2;
    localparam int NA   = 32;
    localparam int NB   = 20;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NA), .NRD(NRD)) ifa ();
    regfile_mp_if #(.XLEN(XLEN), .NREG(NB), .NRD(NRD)) ifb ();

    regfile_mp #(
        .XLEN(XLEN), .NREG(NA), .NRD(NRD), .BYPASS(1)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    regfile_mp #(
        .XLEN(XLEN), .NREG(NB), .NRD(NRD), .BYPASS(0)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    typedef struct {
        logic          we0;
        logic [AW-1:0] a0;
        logic [63:0]   d0;
        logic          we1;
        logic [AW-1:0] a1;
        logic [63:0]   d1;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;
        logic [63:0]   ea0;
        logic [63:0]   ea1;
        logic [63:0]   eb0;
        logic [63:0]   eb1;
    } vec_t;

    typedef struct {
        string       nm;
        logic [63:0] v;
    } exp_t;

    vec_t vt[15];
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w0, input int a0, input logic [63:0] d0,
                         input logic w1, input int a1, input logic [63:0] d1,
                         input logic clr, input int r0, input int r1);
        ifa.we0 = w0; ifa.waddr0 = AW'(a0); ifa.wdata0 = d0;
        ifa.we1 = w1; ifa.waddr1 = AW'(a1); ifa.wdata1 = d1;
        ifa.clear_req = clr;
        ifa.rd_addr = {AW'(r1), AW'(r0)};
        ifb.we0 = w0; ifb.waddr0 = AW'(a0); ifb.wdata0 = d0;
        ifb.we1 = w1; ifb.waddr1 = AW'(a1); ifb.wdata1 = d1;
        ifb.clear_req = clr;
        ifb.rd_addr = {AW'(r1), AW'(r0)};
    endtask

    function automatic vec_t mk(input logic w0, input int a0,
                                input logic [63:0] d0, input logic w1,
                                input int a1, input logic [63:0] d1,
                                input int r0, input int r1,
                                input logic [63:0] ea0, input logic [63:0] ea1,
                                input logic [63:0] eb0, input logic [63:0] eb1);
        vec_t v;
        v.we0 = w0; v.a0 = AW'(a0); v.d0 = d0;
        v.we1 = w1; v.a1 = AW'(a1); v.d1 = d1;
        v.r0 = AW'(r0); v.r1 = AW'(r1);
        v.ea0 = ea0; v.ea1 = ea1; v.eb0 = eb0; v.eb1 = eb1;
        return v;
    endfunction

    // Counts busy cycles of both instances, sampled on negedges, until both
    // are idle. Writes/clear_req are dropped after stop_at samples.
    task automatic count_busy(input int limit, input int stop_at,
                              output int na, output int nb, output int nz);
        na = 0; nb = 0; nz = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ifa.init_busy) na++;
            if (ifb.init_busy) nb++;
            if (ifa.init_busy && ifa.rd_data != '0) nz++;
            if (ifb.init_busy && ifb.rd_data != '0) nz++;
            if (i == stop_at) begin
                ifa.we0 = 1'b0; ifa.we1 = 1'b0; ifa.clear_req = 1'b0;
                ifb.we0 = 1'b0; ifb.we1 = 1'b0; ifb.clear_req = 1'b0;
            end
            if (!ifa.init_busy && !ifb.init_busy) break;
        end
    endtask

    task automatic read_both(input int r0, input int r1,
                             input logic [63:0] e0, input logic [63:0] e1,
                             input string nm);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, r0, r1);
        @(negedge clk);
        check({nm, " A0"}, ifa.rd_data[0 +: XLEN], e0);
        check({nm, " A1"}, ifa.rd_data[XLEN +: XLEN], e1);
        check({nm, " B0"}, ifb.rd_data[0 +: XLEN], e0);
        check({nm, " B1"}, ifb.rd_data[XLEN +: XLEN], e1);
    endtask

    initial begin
        int na, nb, nz;
        exp_t e;

        vt[0]  = mk(1, 5, 64'hDEADBEEF, 0, 0, 0, 5, 5,
                    64'hDEADBEEF, 64'hDEADBEEF, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 5, 0,
                    64'hDEADBEEF, 0, 64'hDEADBEEF, 0);
        vt[2]  = mk(1, 7, 64'h11, 1, 7, 64'h22, 7, 7,
                    64'h22, 64'h22, 0, 0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 7, 5,
                    64'h22, 64'hDEADBEEF, 64'h22, 64'hDEADBEEF);
        vt[4]  = mk(1, 3, 64'h33, 1, 4, 64'h44, 3, 4,
                    64'h33, 64'h44, 0, 0);
        vt[5]  = mk(0, 0, 0, 0, 0, 0, 3, 4,
                    64'h33, 64'h44, 64'h33, 64'h44);
        vt[6]  = mk(1, 0, 64'h55, 1, 25, 64'h77, 0, 25,
                    0, 64'h77, 0, 0);
        vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 25,
                    0, 64'h77, 0, 0);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 5, 7,
                    64'hDEADBEEF, 64'h22, 64'hDEADBEEF, 64'h22);
        vt[9]  = mk(1, 19, 64'h1919, 0, 0, 0, 19, 19,
                    64'h1919, 64'h1919, 0, 0);
        vt[10] = mk(0, 0, 0, 0, 0, 0, 19, 0,
                    64'h1919, 0, 64'h1919, 0);
        vt[11] = mk(1, 31, 64'hE0, 1, 31, 64'hF1, 31, 3,
                    64'hF1, 64'h33, 0, 64'h33);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 31, 4,
                    64'hF1, 64'h44, 0, 64'h44);
        vt[13] = mk(1, 3, 64'h333, 0, 0, 0, 3, 3,
                    64'h333, 64'h333, 64'h33, 64'h33);
        vt[14] = mk(0, 0, 0, 0, 0, 0, 3, 3,
                    64'h333, 64'h333, 64'h333, 64'h333);

        // Reset and initial clear.
        drive(0, 0, 0, 0, 0, 0, 0, 5, 9);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy A", 64'(ifa.init_busy), 1);
        check("reset busy B", 64'(ifb.init_busy), 1);
        check("reset rd A", ifa.rd_data[63:0], 0);
        check("reset rd B", ifb.rd_data[63:0], 0);
        @(posedge clk); #1;
        reset = 1'b0;
        count_busy(100, 200, na, nb, nz);
        check("init cycles A", 64'(na), 31);
        check("init cycles B", 64'(nb), 19);
        check("init rd zero", 64'(nz), 0);

        for (int a = 0; a < NA; a++) begin
            @(posedge clk); #1;
            drive(0, 0, 0, 0, 0, 0, 0, a, a);
            @(negedge clk);
            check($sformatf("post-init A x%0d", a), ifa.rd_data[0 +: XLEN], 0);
            check($sformatf("post-init B x%0d", a), ifb.rd_data[XLEN +: XLEN], 0);
        end

        // Vector table through the scoreboard.
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            drive(vt[i].we0, int'(vt[i].a0), vt[i].d0,
                  vt[i].we1, int'(vt[i].a1), vt[i].d1,
                  0, int'(vt[i].r0), int'(vt[i].r1));
            sbq.push_back('{$sformatf("vec%0d A0", i), vt[i].ea0});
            sbq.push_back('{$sformatf("vec%0d A1", i), vt[i].ea1});
            sbq.push_back('{$sformatf("vec%0d B0", i), vt[i].eb0});
            sbq.push_back('{$sformatf("vec%0d B1", i), vt[i].eb1});
            @(negedge clk);
            e = sbq.pop_front(); check(e.nm, ifa.rd_data[0 +: XLEN], e.v);
            e = sbq.pop_front(); check(e.nm, ifa.rd_data[XLEN +: XLEN], e.v);
            e = sbq.pop_front(); check(e.nm, ifb.rd_data[0 +: XLEN], e.v);
            e = sbq.pop_front(); check(e.nm, ifb.rd_data[XLEN +: XLEN], e.v);
        end

        // Clear request with a same-cycle write that must be dropped.
        @(posedge clk); #1;
        drive(1, 9, 64'h99, 0, 0, 0, 0, 9, 10);
        @(posedge clk); #1;
        drive(1, 10, 64'hAA, 0, 0, 0, 1, 9, 10);
        @(negedge clk);
        check("clr cycle A x9", ifa.rd_data[0 +: XLEN], 64'h99);
        check("clr cycle A x10", ifa.rd_data[XLEN +: XLEN], 0);
        check("clr cycle B x9", ifb.rd_data[0 +: XLEN], 64'h99);
        check("clr cycle busy", 64'(ifa.init_busy), 0);
        // Write and repeated clear_req during busy: both ignored.
        @(posedge clk); #1;
        drive(1, 12, 64'hCC, 1, 13, 64'hDD, 1, 9, 10);
        count_busy(100, 3, na, nb, nz);
        check("clear cycles A", 64'(na), 31);
        check("clear cycles B", 64'(nb), 19);
        check("clear rd zero", 64'(nz), 0);
        read_both(9, 10, 0, 0, "after clear x9/x10");
        read_both(12, 13, 0, 0, "after clear x12/x13");
        read_both(5, 3, 0, 0, "after clear x5/x3");

        // Reset mid-INIT restarts the full sequence.
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 1, 9, 10);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 9, 10);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("mid-init reset busy A %0d", i),
                  64'(ifa.init_busy), 1);
            check($sformatf("mid-init reset busy B %0d", i),
                  64'(ifb.init_busy), 1);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        count_busy(100, 200, na, nb, nz);
        check("restart cycles A", 64'(na), 31);
        check("restart cycles B", 64'(nb), 19);

        // First idle cycle accepts a write with bypass behaviour intact.
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 2, 64'h2222, 0, 2, 2);
        @(negedge clk);
        check("post-restart bypass A", ifa.rd_data[0 +: XLEN], 64'h2222);
        check("post-restart nobyp B", ifb.rd_data[0 +: XLEN], 0);
        read_both(2, 0, 64'h2222, 0, "post-restart x2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core ID stage. It provides NRD combinational read ports and two write ports with fixed priority, plus optional same-cycle write-to-read bypass. A hardware clear sequencer zeroes the array after reset or on request. Entry 0 is hardwired to zero.

## Interface
- XLEN, 64: data width in bits.
- NREG, 32: number of entries, 2..256; need not be a power of two.
- NRD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = a read of an address being written this cycle returns the write data; 0 = it returns the stored value.
- AW, $clog2(NREG): address width, derived; do not override.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- clear_req  in  1  one-cycle pulse that starts a clear sequence; honoured only in IDLE.
- rd_addr  in  NRD*AW  read addresses; port i is bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i is bits [i*XLEN +: XLEN]; combinational.
- we0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1, which has priority over port 0.
- waddr1  in  AW  write address, port 1.
- wdata1  in  XLEN  write data, port 1.
- init_busy  out  1  registered; high while the clear sequence runs.

## Operation
- The FSM has two states, INIT and IDLE, and a pointer ptr of width AW.
- While reset is high:
  - state is INIT, ptr = 1, init_busy = 1.
  - The array is not modified.
  - rd_data = 0 on all ports.
- INIT, each edge with reset low:
  - Entry[ptr] is set to 0 and ptr increments.
  - The edge that clears entry NREG-1 moves the FSM to IDLE and drives init_busy to 0.
- IDLE with clear_req = 1 at an edge: next state is INIT with ptr = 1 and init_busy = 1. Any we0/we1 writes in that same cycle are dropped.
- clear_req is ignored in INIT; the sequence is neither restarted nor extended.
- Writes:
  - Writes apply only in IDLE with clear_req = 0.
  - A port writes if its we is high, its address is nonzero, and its address is < NREG.
  - If both ports target the same address, port 1's data is stored.
  - Different addresses are written in the same edge.
- In INIT, all we0/we1 writes are dropped silently; the requester must watch init_busy.
- Reads, for each port independently:
  - If init_busy = 1, address = 0, or address >= NREG: data = 0.
  - Else if BYPASS = 1 and the address matches a write that is valid this cycle: port 1's data if it matches, otherwise port 0's.
  - Otherwise: the stored entry.
- Entry 0 is never stored. Implementations must not rely on its array content.

## Timing
- Read latency is 0 cycles (combinational from rd_addr and the array).
- A write is visible on the same cycle when BYPASS = 1, and from the cycle after the edge when BYPASS = 0.
- After reset deasserts, init_busy stays high for exactly NREG-1 cycles:
  - The first edge with reset low clears entry 1.
  - The first write is accepted on edge NREG.
- A clear_req accepted at edge k:
  - init_busy is high from after edge k through edge k+NREG-1.
  - IDLE resumes after edge k+NREG-1.
- Reset asserted mid-INIT restarts the sequence: ptr = 1 and the full NREG-1 cycle count applies after release.
- Reset asserted in IDLE: contents are preserved until the post-release clear sequence overwrites them.
- ptr never wraps, because the sequence ends at NREG-1.

## Test plan
- Reset, then release, with NREG = 32:
  - init_busy reads 1 for exactly 31 cycles, then 0.
  - All rd_data = 0 throughout.
  - Afterwards, every address reads 0.
- Write 0xDEAD_BEEF to x5 via port 0:
  - BYPASS = 1: rd_addr = 5 returns 0xDEAD_BEEF in the same cycle.
  - BYPASS = 0: it returns 0 in the same cycle and 0xDEAD_BEEF in the next.
- we0 and we1 both target x7 with 0x11 and 0x22:
  - x7 reads 0x22 the next cycle.
  - Simultaneous writes of x3 = 0x33 (port 0) and x4 = 0x44 (port 1) both land.
- Write 0x55 to x0, and with NREG = 20 write address 25:
  - rd_addr = 0 and rd_addr = 25 both read 0.
  - No other entry changes.
- With x9 = 0x99, pulse clear_req together with a port 0 write of x10 = 0xAA:
  - init_busy rises the next cycle and stays high 31 cycles.
  - Afterwards x9 and x10 read 0.
  - A write attempted during busy leaves no trace.
- Assert reset after 10 cycles of INIT and hold it 2 cycles:
  - init_busy stays high.
  - After release it stays high for a further 31 cycles.
